// File: rtl/flexible_downsampling_stream.sv
// flexible_downsampling_stream: streaming nearest-neighbour downsampler with Q8.8 stride and floor/round index.
module flexible_downsampling_stream #(
  parameter int DATA_W = 8,
  parameter int HIN_MAX = 64,
  parameter int CIN_MAX = 512,
  parameter int ACC_W = $clog2(HIN_MAX) + 9,
  localparam int CW = $clog2(CIN_MAX + 1),
  localparam int HW = $clog2(HIN_MAX + 1),
  localparam int OW = $clog2(CIN_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     cfg_cin,
  input  logic [HW-1:0]     cfg_hin,
  input  logic [HW-1:0]     cfg_hout,
  input  logic [15:0]       cfg_stride,
  input  logic              cfg_round,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OW-1:0]     out_ch,
  output logic              out_last,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [HW-1:0] H1 = HW'(1);
  state_t state, state_nx;
  logic [CW-1:0] cin_r, ch;
  logic [HW-1:0] hin_r, hout_r, ix, iy, ox, oy;
  logic [15:0] stride_r;
  logic rnd_r;
  logic [ACC_W-1:0] accx, accy, rnd_off;
  logic [HW+16:0] pos_chk;
  logic cfg_ok, sel, accept, col_end, row_end, ch_end, ox_end, oy_end;
  // Last output position of the requested job, checked against the input side before accepting it.
  assign pos_chk = (HW+17)'(cfg_hout - H1) * (HW+17)'(cfg_stride) + (cfg_round ? (HW+17)'(128) : '0);
  assign cfg_ok = cfg_cin != '0 && cfg_cin <= CW'(CIN_MAX) && cfg_hout != '0 && cfg_hout <= cfg_hin &&
                  cfg_hin <= HW'(HIN_MAX) && cfg_stride >= 16'd256 && pos_chk[HW+16:8] < (HW+9)'(cfg_hin);
  assign rnd_off = rnd_r ? ACC_W'(128) : '0;
  assign col_end = ix == hin_r - H1;
  assign row_end = iy == hin_r - H1;
  assign ch_end = ch == cin_r - CW'(1);
  assign ox_end = ox == hout_r - H1;
  assign oy_end = oy == hout_r - H1;
  assign sel = state == RUN && iy == HW'(accy >> 8) && ix == HW'(accx >> 8) && oy < hout_r && ox < hout_r;
  assign in_ready = state == RUN && (!sel || !out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start && cfg_ok ? RUN : IDLE;
      RUN:     state_nx = accept && col_end && row_end && ch_end ? DRAIN : RUN;
      DRAIN:   state_nx = out_valid ? DRAIN : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {cin_r, hin_r, hout_r, stride_r, rnd_r} <= '0;
      {ix, iy, ch, ox, oy, accx, accy} <= '0;
      {out_valid, out_data, out_ch, out_last, err} <= '0;
    end else begin
      state <= state_nx;
      err <= state == IDLE && start && !cfg_ok;
      if (state == IDLE && start) begin
        {cin_r, hin_r, hout_r, stride_r, rnd_r} <= {cfg_cin, cfg_hin, cfg_hout, cfg_stride, cfg_round};
        {ix, iy, ch, ox, oy} <= '0;
        accx <= cfg_round ? ACC_W'(128) : '0;
        accy <= cfg_round ? ACC_W'(128) : '0;
      end
      if (accept) begin
        ix <= col_end ? '0 : ix + H1;
        if (col_end) iy <= row_end ? '0 : iy + H1;
        if (col_end && row_end) begin
          ch <= ch + CW'(1);
          {ox, oy} <= '0;
          accx <= rnd_off;
          accy <= rnd_off;
        end else if (sel) begin
          ox <= ox_end ? '0 : ox + H1;
          accx <= ox_end ? rnd_off : accx + ACC_W'(stride_r);
          if (ox_end) oy <= oy + H1;
          // Past the final output row accy is never compared, so it is left alone.
          if (ox_end && !oy_end) accy <= accy + ACC_W'(stride_r);
        end
      end
      if (accept && sel) begin
        out_valid <= 1'b1;
        out_data <= in_data;
        out_ch <= OW'(ch);
        out_last <= ox_end && oy_end;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_flexible_downsampling_stream.sv
// tb_flexible_downsampling_stream: random jobs against an arithmetic resampling model with a queued scoreboard.
module tb_flexible_downsampling_stream;
  logic clk = 0, rst, start, busy, in_valid, in_ready, out_valid, out_ready, out_last, done, err, cfg_round;
  logic [9:0] cfg_cin;
  logic [6:0] cfg_hin, cfg_hout;
  logic [15:0] cfg_stride;
  logic [7:0] in_data, out_data;
  logic [8:0] out_ch;
  typedef struct packed {logic [7:0] d; logic [8:0] ch; logic last;} exp_t;
  exp_t q[$];
  exp_t e_m;
  logic stall_m;
  logic [7:0] sd_m;
  int checks = 0, errors = 0, done_cnt = 0, rduty = 100;
  flexible_downsampling_stream dut (.clk(clk), .rst(rst), .start(start), .cfg_cin(cfg_cin), .cfg_hin(cfg_hin),
    .cfg_hout(cfg_hout), .cfg_stride(cfg_stride), .cfg_round(cfg_round), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .done(done), .err(err));
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ch"}, out_ch, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  task automatic set_cfg(int cin, int hin, int hout, int stride, int rnd);
    cfg_cin = 10'(cin);
    cfg_hin = 7'(hin);
    cfg_hout = 7'(hout);
    cfg_stride = 16'(stride);
    cfg_round = 1'(rnd);
  endtask
  task automatic run_job(int cin, int hin, int hout, int stride, int rnd, int vduty, int abort_at, int mid_start);
    int idx[$];
    logic [7:0] pix[];
    int n, acc, cyc, base_done;
    logic got;
    n = cin * hin * hin;
    pix = new[n];
    foreach (pix[i]) pix[i] = 8'($urandom);
    for (int o = 0; o < hout; o++) idx.push_back((o * stride + (rnd != 0 ? 128 : 0)) / 256);
    for (int c = 0; c < cin; c++)
      for (int y = 0; y < hout; y++)
        for (int x = 0; x < hout; x++)
          q.push_back(exp_t'{d: pix[c*hin*hin + idx[y]*hin + idx[x]], ch: 9'(c), last: (y == hout-1 && x == hout-1)});
    @(posedge clk); #1;
    set_cfg(cin, hin, hout, stride, rnd);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
    base_done = done_cnt;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 40000) begin
      in_valid = $urandom_range(99) < vduty;
      in_data = pix[acc];
      start = cyc == mid_start;
      if (cyc == mid_start) set_cfg(1, 5, 5, 256, 0);
      @(negedge clk);
      chk("in_ready_rule", int'(in_ready || (out_valid && !out_ready)), 1);
      got = in_valid && in_ready;
      @(posedge clk); #1;
      if (got) acc++;
      cyc++;
      if (abort_at > 0 && acc == abort_at) begin
        rst = 1;
        in_valid = 0;
        start = 0;
        @(posedge clk); #1;
        chk_zero("mid_reset");
        rst = 0;
        q.delete();
        return;
      end
    end
    in_valid = 0;
    start = 0;
    chk("inputs_consumed", acc, n);
    cyc = 0;
    while (done_cnt == base_done && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done_cnt - base_done, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - base_done, 1);
    chk("queue_empty", q.size(), 0);
    chk("idle_after_job", busy, 0);
  endtask
  task automatic reject(int cin, int hin, int hout, int stride, int rnd);
    @(posedge clk); #1;
    set_cfg(cin, hin, hout, stride, rnd);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("reject_err", err, 1);
    chk("reject_busy", busy, 0);
    chk("reject_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("reject_err_pulse", err, 0);
    chk("reject_busy_after", busy, 0);
  endtask
  initial begin
    rst = 1;
    start = 0;
    in_valid = 0;
    in_data = 0;
    out_ready = 1;
    stall_m = 0;
    set_cfg(1, 8, 8, 256, 0);
    fork
      forever begin
        @(posedge clk); #1;
        out_ready = $urandom_range(99) < rduty;
      end
      forever begin
        @(negedge clk);
        if (rst) stall_m = 0;
        else begin
          if (done) done_cnt++;
          if (stall_m) begin
            chk("stall_hold", out_valid, 1);
            chk("stall_data", out_data, sd_m);
          end
          if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
              e_m = q.pop_front();
              chk("out_data", out_data, e_m.d);
              chk("out_ch", out_ch, e_m.ch);
              chk("out_last", out_last, e_m.last);
            end
          end
          stall_m = out_valid && !out_ready;
          sd_m = out_data;
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    run_job(4, 27, 19, 369, 0, 100, 0, -1);
    run_job(4, 27, 19, 369, 1, 100, 0, -1);
    rduty = 30;
    run_job(2, 27, 19, 369, 0, 80, 0, -1);
    rduty = 70;
    run_job(2, 8, 8, 256, 0, 90, 0, -1);
    reject(1, 8, 4, 200, 0);
    reject(1, 10, 8, 384, 0);
    rduty = 60;
    run_job(2, 16, 10, 400, 0, 90, 150, -1);
    run_job(2, 16, 10, 400, 1, 90, 0, -1);
    rduty = 100;
    run_job(3, 12, 7, 300, 0, 100, 0, 50);
    rduty = 50;
    for (int k = 0; k < 3; k++) begin
      int hin, hout, rnd, smax;
      hin = $urandom_range(16, 2);
      hout = $urandom_range(hin, 1);
      rnd = $urandom_range(1, 0);
      smax = hout > 1 ? (hin * 256 - 1 - rnd * 128) / (hout - 1) : 600;
      if (smax > 4000) smax = 4000;
      run_job($urandom_range(3, 1), hin, hout, $urandom_range(smax, 256), rnd, 75, 0, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
